// File: rtl/ram_rr_scheduler.sv
// Round-robin scheduler sharing one registered-read RAM among request/ack clients.
// Optionally zeroes the whole RAM after reset before any client is served.
module ram_rr_scheduler #(
   parameter int unsigned G_ADDR_WIDTH     = 4,
   parameter int unsigned G_DATA_WIDTH     = 8,
   parameter int unsigned G_NUM_CLIENTS    = 4,
   parameter int unsigned G_ID_WIDTH       = 2,
   parameter int unsigned G_CLEAR_ON_RESET = 1
) (
   input  logic                                   CLOCK,
   input  logic                                   RST_N,
   output logic                                   RST_DONE,
   input  logic [G_NUM_CLIENTS-1:0]               REQUEST,
   input  logic [G_NUM_CLIENTS-1:0]               RD_NOT_WRITE,
   input  logic [G_NUM_CLIENTS*G_ADDR_WIDTH-1:0]  ADDR,
   input  logic [G_NUM_CLIENTS*G_DATA_WIDTH-1:0]  DATAIN,
   output logic [G_NUM_CLIENTS-1:0]               ACK,
   output logic [G_DATA_WIDTH-1:0]                DATAOUT,
   output logic [G_ID_WIDTH-1:0]                  GRANT_ID,
   output logic                                   RD_EN,
   output logic                                   WR_EN,
   output logic [G_ADDR_WIDTH-1:0]                RD_ADDR,
   output logic [G_ADDR_WIDTH-1:0]                WR_ADDR,
   output logic [G_DATA_WIDTH-1:0]                WR_DATA,
   input  logic [G_DATA_WIDTH-1:0]                RD_DATA
);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t                    state_q;
   logic [G_ADDR_WIDTH-1:0]   clr_q;
   logic [G_ID_WIDTH-1:0]     ptr_q;
   logic [G_ID_WIDTH-1:0]     gnt_q;
   logic                      rnw_q;
   logic                      done_q;
   logic [G_NUM_CLIENTS-1:0]  ack_q;
   logic [G_DATA_WIDTH-1:0]   dout_q;
   logic                      rd_en_q;
   logic                      wr_en_q;
   logic [G_ADDR_WIDTH-1:0]   rd_addr_q;
   logic [G_ADDR_WIDTH-1:0]   wr_addr_q;
   logic [G_DATA_WIDTH-1:0]   wr_data_q;

   logic                      gnt_valid_d;
   logic [G_ID_WIDTH-1:0]     gnt_id_d;
   logic                      gnt_rnw_d;
   logic [G_ADDR_WIDTH-1:0]   gnt_addr_d;
   logic [G_DATA_WIDTH-1:0]   gnt_data_d;
   logic [G_NUM_CLIENTS-1:0]  ack_d;

   // First requester found searching upward from the last-granted client, wrapping.
   always_comb begin
      gnt_valid_d = 1'b0;
      gnt_id_d    = '0;
      gnt_rnw_d   = 1'b0;
      gnt_addr_d  = '0;
      gnt_data_d  = '0;
      for (int unsigned i = 1; i <= G_NUM_CLIENTS; i++) begin
         for (int unsigned k = 0; k < G_NUM_CLIENTS; k++) begin
            if (!gnt_valid_d && REQUEST[k] &&
                (k == (32'(ptr_q) + i) % G_NUM_CLIENTS)) begin
               gnt_valid_d = 1'b1;
               gnt_id_d    = G_ID_WIDTH'(k);
               gnt_rnw_d   = RD_NOT_WRITE[k];
               gnt_addr_d  = ADDR[k*G_ADDR_WIDTH +: G_ADDR_WIDTH];
               gnt_data_d  = DATAIN[k*G_DATA_WIDTH +: G_DATA_WIDTH];
            end
         end
      end
      ack_d = '0;
      for (int unsigned k = 0; k < G_NUM_CLIENTS; k++) begin
         ack_d[k] = (gnt_q == G_ID_WIDTH'(k));
      end
   end

   // Outputs are registered one state ahead: the grant edge already drives the RAM
   // port, so the read data is back in time for the edge that raises ACK.
   always_ff @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= (G_CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         clr_q     <= '0;
         ptr_q     <= G_ID_WIDTH'(G_NUM_CLIENTS - 1);
         gnt_q     <= '0;
         rnw_q     <= 1'b0;
         done_q    <= 1'b0;
         ack_q     <= '0;
         dout_q    <= '0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         ack_q   <= '0;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         case (state_q)
            S_CLEAR: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= clr_q;
               wr_data_q <= '0;
               clr_q     <= clr_q + 1'b1;
               if (clr_q == '1) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end
            end
            S_IDLE: begin
               done_q <= 1'b1;
               if (gnt_valid_d) begin
                  gnt_q   <= gnt_id_d;
                  ptr_q   <= gnt_id_d;
                  rnw_q   <= gnt_rnw_d;
                  state_q <= S_ACCESS;
                  if (gnt_rnw_d) begin
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= gnt_addr_d;
                  end else begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= gnt_addr_d;
                     wr_data_q <= gnt_data_d;
                  end
               end
            end
            S_ACCESS: begin
               state_q <= S_DONE;
            end
            S_DONE: begin
               ack_q <= ack_d;
               if (rnw_q) begin
                  dout_q <= RD_DATA;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign RST_DONE = done_q;
   assign ACK      = ack_q;
   assign DATAOUT  = dout_q;
   assign GRANT_ID = gnt_q;
   assign RD_EN    = rd_en_q;
   assign WR_EN    = wr_en_q;
   assign RD_ADDR  = rd_addr_q;
   assign WR_ADDR  = wr_addr_q;
   assign WR_DATA  = wr_data_q;

endmodule

// File: tb/tb_ram_rr_scheduler.sv
// Bench for ram_rr_scheduler: RAM behavioural model, transaction-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_ram_rr_scheduler;

   localparam int AW      = 4;
   localparam int DW      = 8;
   localparam int N       = 4;
   localparam int IDW     = 2;
   localparam int CLR     = 1;
   localparam int DEPTH   = 1 << AW;
   localparam int CLR_CYC = (CLR != 0) ? DEPTH : 0;

   logic              CLOCK = 1'b0;
   logic              RST_N = 1'b1;
   logic              RST_DONE;
   logic [N-1:0]      REQUEST;
   logic [N-1:0]      RD_NOT_WRITE;
   logic [N*AW-1:0]   ADDR;
   logic [N*DW-1:0]   DATAIN;
   logic [N-1:0]      ACK;
   logic [DW-1:0]     DATAOUT;
   logic [IDW-1:0]    GRANT_ID;
   logic              RD_EN;
   logic              WR_EN;
   logic [AW-1:0]     RD_ADDR;
   logic [AW-1:0]     WR_ADDR;
   logic [DW-1:0]     WR_DATA;
   logic [DW-1:0]     RD_DATA;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLOCK = ~CLOCK;

   ram_rr_scheduler #(
      .G_ADDR_WIDTH    (AW),
      .G_DATA_WIDTH    (DW),
      .G_NUM_CLIENTS   (N),
      .G_ID_WIDTH      (IDW),
      .G_CLEAR_ON_RESET(CLR)
   ) dut (
      .CLOCK       (CLOCK),
      .RST_N       (RST_N),
      .RST_DONE    (RST_DONE),
      .REQUEST     (REQUEST),
      .RD_NOT_WRITE(RD_NOT_WRITE),
      .ADDR        (ADDR),
      .DATAIN      (DATAIN),
      .ACK         (ACK),
      .DATAOUT     (DATAOUT),
      .GRANT_ID    (GRANT_ID),
      .RD_EN       (RD_EN),
      .WR_EN       (WR_EN),
      .RD_ADDR     (RD_ADDR),
      .WR_ADDR     (WR_ADDR),
      .WR_DATA     (WR_DATA),
      .RD_DATA     (RD_DATA)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM: garbage contents at start so the clear sequence matters.
   logic [DW-1:0] ram [DEPTH];
   bit            ram_init;
   always @(posedge CLOCK) begin
      if (!ram_init) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= DW'($urandom);
         RD_DATA  <= '0;
         ram_init <= 1'b1;
      end else begin
         if (WR_EN) ram[WR_ADDR] <= WR_DATA;
         if (RD_EN) RD_DATA <= ram[RD_ADDR];
      end
   end

   // Reference model: cycle count since reset, clear window, then one transaction
   // per 3 edges; grant edge drives the RAM port, ACK follows two edges later.
   int             cyc, next_free, last, t_grant, t_id, m_w;
   bit             have_txn, t_rnw;
   logic [DW-1:0]  t_rdval, m_d;
   logic [AW-1:0]  m_a;
   logic [DW-1:0]  mem_ref [DEPTH];
   logic           e_done, e_rd, e_wr;
   logic [N-1:0]   e_ack;
   logic [IDW-1:0] e_gid;
   logic [DW-1:0]  e_dout, e_wdata;
   logic [AW-1:0]  e_waddr, e_raddr;

   always @(posedge CLOCK or negedge RST_N) begin
      if (!RST_N) begin
         cyc = 0; next_free = 0; last = N - 1; have_txn = 0;
         e_done = 0; e_rd = 0; e_wr = 0; e_ack = '0; e_gid = '0; e_dout = '0;
         e_wdata = '0; e_waddr = '0; e_raddr = '0;
      end else begin
         e_rd = 0; e_wr = 0; e_ack = '0;
         if (cyc < CLR_CYC) begin
            e_wr = 1; e_waddr = AW'(cyc); e_wdata = '0; mem_ref[cyc] = '0;
            e_done = (cyc == CLR_CYC - 1);
         end else begin
            e_done = 1;
            if (have_txn && cyc == t_grant + 2) begin
               e_ack[t_id] = 1'b1;
               if (t_rnw) e_dout = t_rdval;
            end
            if (cyc >= next_free && REQUEST != '0) begin
               m_w = -1;
               for (int i = 1; i <= N; i++)
                  if (m_w < 0 && REQUEST[(last + i) % N]) m_w = (last + i) % N;
               m_a = ADDR[m_w*AW +: AW];
               m_d = DATAIN[m_w*DW +: DW];
               t_grant = cyc; t_id = m_w; t_rnw = RD_NOT_WRITE[m_w]; have_txn = 1;
               last = m_w; next_free = cyc + 3; e_gid = IDW'(m_w);
               if (t_rnw) begin
                  e_rd = 1; e_raddr = m_a; t_rdval = mem_ref[m_a];
               end else begin
                  e_wr = 1; e_waddr = m_a; e_wdata = m_d; mem_ref[m_a] = m_d;
               end
            end
         end
         cyc++;
      end
   end

   always @(negedge CLOCK) begin
      if (RST_N) begin
         check("m_rst_done", RST_DONE, e_done);
         check("m_rd_en", RD_EN, e_rd);
         check("m_wr_en", WR_EN, e_wr);
         check("m_ack", ACK, e_ack);
         check("m_grant_id", GRANT_ID, e_gid);
         check("m_dataout", DATAOUT, e_dout);
         if (e_wr) begin
            check("m_wr_addr", WR_ADDR, e_waddr);
            check("m_wr_data", WR_DATA, e_wdata);
         end
         if (e_rd) check("m_rd_addr", RD_ADDR, e_raddr);
      end
   end

   task automatic set_client(input int k, input bit rnw, input int a, input int d);
      RD_NOT_WRITE[k]   = rnw;
      ADDR[k*AW +: AW]  = AW'(a);
      DATAIN[k*DW +: DW] = DW'(d);
   endtask

   task automatic do_txn(input int k, input bit rnw, input int a, input int d,
                         output int lat, output logic [DW-1:0] dout);
      bit seen;
      seen = 0;
      lat  = 0;
      set_client(k, rnw, a, d);
      REQUEST[k] = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLOCK);
         lat++;
         if (ACK[k]) seen = 1;
      end
      REQUEST[k] = 1'b0;
      dout = DATAOUT;
      check("txn_ack_seen", 32'(seen), 1);
   endtask

   int got_id [8];
   int got_cyc[8];
   task automatic collect(input int n);
      int got, c;
      got = 0;
      c   = 0;
      while (got < n && c < 60) begin
         @(negedge CLOCK);
         c++;
         if (ACK != '0) begin
            for (int b = 0; b < N; b++) if (ACK[b]) got_id[got] = b;
            got_cyc[got] = c;
            got++;
         end
      end
      REQUEST = '0;
      check("collect_count", got, n);
   endtask

   task automatic apply_reset();
      @(negedge CLOCK);
      #2 RST_N = 1'b0;
      @(negedge CLOCK);
      @(negedge CLOCK);
      RST_N = 1'b1;
   endtask

   int exp_rr[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      int            lat, c;
      bit            seen;
      logic [DW-1:0] dout;

      REQUEST = '0; RD_NOT_WRITE = '0; ADDR = '0; DATAIN = '0;
      #1 RST_N = 1'b0;
      repeat (3) @(negedge CLOCK);
      check("rst_done_in_reset", RST_DONE, 0);
      check("wr_en_in_reset", WR_EN, 0);
      check("rd_en_in_reset", RD_EN, 0);
      check("ack_in_reset", ACK, 0);
      check("dataout_in_reset", DATAOUT, 0);
      check("grant_id_in_reset", GRANT_ID, 0);

      // Clear sequence: 16 writes of zero, RST_DONE with the last one.
      RST_N = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge CLOCK);
         check("clr_wr_en", WR_EN, 1);
         check("clr_wr_addr", WR_ADDR, i - 1);
         check("clr_wr_data", WR_DATA, 0);
         check("clr_rst_done", RST_DONE, 32'(i == 16));
      end
      @(negedge CLOCK);
      check("idle_wr_en", WR_EN, 0);

      do_txn(0, 1'b1, 0, 0, lat, dout);
      check("rd_addr0_zero", dout, 0);
      check("rd_latency", lat, 3);
      do_txn(3, 1'b1, 15, 0, lat, dout);
      check("rd_addr15_zero", dout, 0);

      do_txn(1, 1'b0, 3, 8'hA5, lat, dout);
      check("wr_latency", lat, 3);
      do_txn(2, 1'b1, 3, 0, lat, dout);
      check("raw_data", dout, 8'hA5);
      check("raw_latency", lat, 3);

      // All clients requesting right after the clear.
      apply_reset();
      repeat (16) @(negedge CLOCK);
      check("rst_done_after_clear", RST_DONE, 1);
      for (int k = 0; k < N; k++) set_client(k, 1'b0, k, 8'h10 + k);
      REQUEST = '1;
      collect(6);
      check("first_ack_cycle", got_cyc[0], 3);
      for (int i = 0; i < 6; i++) check("rr_order", got_id[i], exp_rr[i]);
      for (int i = 1; i < 6; i++) check("ack_spacing", got_cyc[i] - got_cyc[i-1], 3);

      // Rotation: after client 2, client 3 beats client 1.
      do_txn(2, 1'b0, 9, 8'h77, lat, dout);
      check("rot_c2_latency", lat, 3);
      set_client(1, 1'b1, 9, 0);
      set_client(3, 1'b1, 1, 0);
      REQUEST = 4'b1010;
      collect(2);
      check("rot_first", got_id[0], 3);
      check("rot_second", got_id[1], 1);

      // Request raised in cycle 2 of the clear.
      apply_reset();
      c = 0;
      repeat (2) begin @(negedge CLOCK); c++; end
      set_client(0, 1'b1, 9, 0);
      REQUEST[0] = 1'b1;
      while (c < 60) begin
         @(negedge CLOCK);
         c++;
         if (ACK[0]) break;
      end
      REQUEST[0] = 1'b0;
      check("clear_req_latency", c, 19);
      check("clear_req_data", DATAOUT, 0);

      // Reset during the access cycle of a read.
      do_txn(1, 1'b0, 5, 8'h3C, lat, dout);
      do_txn(2, 1'b1, 5, 0, lat, dout);
      check("pre_reset_read", dout, 8'h3C);
      set_client(3, 1'b1, 5, 0);
      REQUEST[3] = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLOCK);
         if (RD_EN) seen = 1;
      end
      check("mid_rd_en_seen", 32'(seen), 1);
      #2 RST_N = 1'b0;
      #1;
      check("abort_rd_en", RD_EN, 0);
      check("abort_ack", ACK, 0);
      check("abort_dataout", DATAOUT, 0);
      check("abort_rst_done", RST_DONE, 0);
      REQUEST = '0;
      @(negedge CLOCK);
      check("abort_no_ack", ACK, 0);
      @(negedge CLOCK);
      RST_N = 1'b1;
      @(negedge CLOCK);
      check("restart_wr_en", WR_EN, 1);
      check("restart_wr_addr0", WR_ADDR, 0);
      @(negedge CLOCK);
      check("restart_wr_addr1", WR_ADDR, 1);

      c = 0;
      while (!RST_DONE && c < 100) begin @(negedge CLOCK); c++; end
      check("rst_done_before_random", RST_DONE, 1);

      // Random traffic: clients raise requests, mostly drop them on ACK.
      for (int n = 0; n < 3000; n++) begin
         @(negedge CLOCK);
         for (int k = 0; k < N; k++) begin
            if (REQUEST[k]) begin
               if (ACK[k] && $urandom_range(0, 3) != 0) REQUEST[k] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               REQUEST[k] = 1'b1;
            end
            set_client(k, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                       int'($urandom_range(0, 255)));
         end
      end
      REQUEST = '0;
      repeat (5) @(negedge CLOCK);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule
